// File: rtl/led_pkg.sv
// Shared definitions for the LED frame position counter: FSM state encoding and default GRB frame geometry.
package led_pkg;

  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  localparam int unsigned GRB_BITS_PER_LED = 24;

endpackage

// File: rtl/led_frame_counter_if.sv
// Control/status bundle between the GRB serialiser FSM (master) and the frame counter (slave).
// LEDFC_ACTIVE_LEN_EN adds the per-frame active_len input.
interface led_frame_counter_if #(
  parameter int unsigned BITS_PER_LED = 24,
  parameter int unsigned NUM_LEDS     = 10
);
  localparam int unsigned TOTAL_BITS = BITS_PER_LED * NUM_LEDS;
  localparam int unsigned BW = $clog2(BITS_PER_LED);
  localparam int unsigned LW = $clog2(NUM_LEDS) + 1;
  localparam int unsigned CW = $clog2(TOTAL_BITS + 1);

  logic          clear;
  logic          inc;
  logic [BW-1:0] bit_idx;
  logic [LW-1:0] led_idx;
  logic [CW-1:0] bit_count;
  logic          last_bit;
  logic          last_led;
  logic          done;
`ifdef LEDFC_ACTIVE_LEN_EN
  logic [LW-1:0] active_len;

  modport master (
    output clear, inc, active_len,
    input  bit_idx, led_idx, bit_count, last_bit, last_led, done
  );
  modport slave (
    input  clear, inc, active_len,
    output bit_idx, led_idx, bit_count, last_bit, last_led, done
  );
`else
  modport master (
    output clear, inc,
    input  bit_idx, led_idx, bit_count, last_bit, last_led, done
  );
  modport slave (
    input  clear, inc,
    output bit_idx, led_idx, bit_count, last_bit, last_led, done
  );
`endif

endinterface

// File: rtl/led_frame_counter.sv
// Frame position tracker for the GRB serialiser: bit-in-LED, LED index, flat bit count and done flag.
// Optional LEDFC_ACTIVE_LEN_EN: frame length in LEDs sampled from active_len on clear.
module led_frame_counter
  import led_pkg::*;
#(
  parameter int unsigned BITS_PER_LED = GRB_BITS_PER_LED,
  parameter int unsigned NUM_LEDS     = 10
) (
  input  logic                clk,
  input  logic                reset,
  led_frame_counter_if.slave  bus
);

  localparam int unsigned TOTAL_BITS = BITS_PER_LED * NUM_LEDS;
  localparam int unsigned BW = $clog2(BITS_PER_LED);
  localparam int unsigned LW = $clog2(NUM_LEDS) + 1;
  localparam int unsigned CW = $clog2(TOTAL_BITS + 1);

  state_t        state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [LW-1:0] led_q, led_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          last_bit_c;
  logic          last_led_c;

  assign last_bit_c = (bit_q == BW'(BITS_PER_LED - 1));

`ifdef LEDFC_ACTIVE_LEN_EN
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] len_sample_c;

  // Out-of-range requests fall back to the full strip.
  assign len_sample_c = ((bus.active_len == '0) || (bus.active_len > LW'(NUM_LEDS)))
                        ? LW'(NUM_LEDS) : bus.active_len;
  assign last_led_c   = (led_q == (len_q - LW'(1)));
`else
  assign last_led_c   = (led_q == LW'(NUM_LEDS - 1));
`endif

  // Next-state: clear beats inc; in DONE every count saturates.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
`ifdef LEDFC_ACTIVE_LEN_EN
    len_d   = len_q;
`endif
    if (bus.clear) begin
      state_d = ST_COUNT;
      bit_d   = '0;
      led_d   = '0;
      cnt_d   = '0;
`ifdef LEDFC_ACTIVE_LEN_EN
      len_d   = len_sample_c;
`endif
    end else if (bus.inc && (state_q == ST_COUNT)) begin
      // Final increment lands exactly on the frame length, so no separate load is needed.
      cnt_d = cnt_q + CW'(1);
      if (last_bit_c && last_led_c) begin
        state_d = ST_DONE;
      end else if (last_bit_c) begin
        bit_d = '0;
        led_d = led_q + LW'(1);
      end else begin
        bit_d = bit_q + BW'(1);
      end
    end
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_COUNT;
      bit_q   <= '0;
      led_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef LEDFC_ACTIVE_LEN_EN
      len_q   <= LW'(NUM_LEDS);
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef LEDFC_ACTIVE_LEN_EN
      len_q   <= len_d;
`endif
    end
  end

  assign bus.bit_idx   = bit_q;
  assign bus.led_idx   = led_q;
  assign bus.bit_count = cnt_q;
  assign bus.last_bit  = last_bit_c;
  assign bus.last_led  = last_led_c;
  assign bus.done      = done_q;

endmodule
